// File: rtl/code_entry_if.sv
// Symbol-entry bus between the keypad side (master) and the code_entry checker (slave).
// The slave drives the lockout/match flags into the downstream pass gate.
interface code_entry_if;
  logic [3:0] sym;
  logic       sym_valid;
  logic       clr;
  logic       x;
  logic       y;
  logic [1:0] cnt;
  logic [1:0] fails;

  modport master (output sym, sym_valid, clr, input x, y, cnt, fails);
  modport slave  (input sym, sym_valid, clr, output x, y, cnt, fails);
endinterface

// File: rtl/code_entry.sv
// Four-symbol code checker with a failed-attempt counter and a timed lockout.
// Drives x (lockout) and y (match) of the downstream pass gate.
module code_entry #(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  code_entry_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MATCH   = 2'd1,
    FAIL    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAIL);
  localparam logic [7:0] LOCK_LOAD  = 8'(LOCK_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [1:0] fails, fails_n;
  logic       mismatch, mismatch_n;
  logic [7:0] timer, timer_n;
  logic       x_q, y_q;
  logic [3:0] expected_sym;
  logic       miss;

  // First symbol of the code sits in the top nibble.
  always_comb begin
    unique case (cnt)
      2'd0:    expected_sym = CODE[15:12];
      2'd1:    expected_sym = CODE[11:8];
      2'd2:    expected_sym = CODE[7:4];
      default: expected_sym = CODE[3:0];
    endcase
  end

  assign miss = mismatch | (bus.sym != expected_sym);

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_n    = state;
    cnt_n      = cnt;
    fails_n    = fails;
    mismatch_n = mismatch;
    timer_n    = timer;

    unique case (state)
      COLLECT: begin
        if (bus.clr) begin
          cnt_n      = 2'd0;
          mismatch_n = 1'b0;
        end else if (bus.sym_valid) begin
          if (cnt == 2'd3) begin
            state_n    = miss ? FAIL : MATCH;
            fails_n    = miss ? fails : 2'd0;
            cnt_n      = 2'd0;
            mismatch_n = 1'b0;
          end else begin
            cnt_n      = cnt + 2'd1;
            mismatch_n = miss;
          end
        end
      end
      MATCH: begin
        if (bus.clr) state_n = COLLECT;
      end
      FAIL: begin
        fails_n = fails + 2'd1;
        if (fails_n == FAIL_LIMIT) begin
          state_n = LOCKOUT;
          timer_n = LOCK_LOAD;
        end else begin
          state_n = COLLECT;
        end
      end
      LOCKOUT: begin
        // Timer was loaded with LOCK_CYCLES-1, so exiting at zero gives exactly LOCK_CYCLES cycles.
        if (timer == 8'd0) begin
          state_n = COLLECT;
          fails_n = 2'd0;
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      cnt      <= 2'd0;
      fails    <= 2'd0;
      mismatch <= 1'b0;
      timer    <= 8'd0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      fails    <= fails_n;
      mismatch <= mismatch_n;
      timer    <= timer_n;
      x_q      <= (state_n == LOCKOUT);
      y_q      <= (state_n == MATCH);
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.cnt   = cnt;
  assign bus.fails = fails;

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: directed scenarios plus biased random
// stimulus, compared each cycle against an attempt-level reference model.
module tb_code_entry;

  localparam logic [15:0] CODE        = 16'h1234;
  localparam int          MAX_FAIL    = 3;
  localparam int          LOCK_CYCLES = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_entry_if bus();

  code_entry #(.CODE(CODE), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the symbols typed so far in this attempt, plus attempt outcomes.
  logic [3:0] entered[$];
  int         m_fails;
  int         lock_left;
  bit         matched;
  bit         fail_pending;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [3:0] code_at(input int i);
    logic [15:0] c;
    c = CODE;
    return c[15 - 4*i -: 4];
  endfunction

  task automatic model_reset();
    entered.delete();
    m_fails      = 0;
    lock_left    = 0;
    matched      = 0;
    fail_pending = 0;
  endtask

  task automatic model_step(input logic [3:0] s, input bit v, input bit c);
    bit ok;
    if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) m_fails = 0;
    end else if (fail_pending) begin
      fail_pending = 0;
      m_fails++;
      if (m_fails == MAX_FAIL) lock_left = LOCK_CYCLES;
    end else if (matched) begin
      if (c) matched = 0;
    end else if (c) begin
      entered.delete();
    end else if (v) begin
      entered.push_back(s);
      if (entered.size() == 4) begin
        ok = 1;
        for (int i = 0; i < 4; i++) if (entered[i] != code_at(i)) ok = 0;
        if (ok) begin
          matched = 1;
          m_fails = 0;
        end else begin
          fail_pending = 1;
        end
        entered.delete();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".x"},     32'(bus.x),       32'(lock_left > 0));
    check({tag, ".y"},     32'(bus.y),       32'(matched));
    check({tag, ".cnt"},   32'(bus.cnt),     32'(entered.size()));
    check({tag, ".fails"}, 32'(bus.fails),   32'(m_fails));
    check({tag, ".gate"},  32'(bus.y & ~bus.x), 32'(matched && lock_left == 0));
  endtask

  task automatic step(input string tag, input logic [3:0] s, input bit v, input bit c);
    bus.sym       = s;
    bus.sym_valid = v;
    bus.clr       = c;
    @(posedge clk);
    model_step(s, v, c);
    #1;
    check_outputs(tag);
  endtask

  task automatic enter4(input string tag, input logic [15:0] code4);
    for (int i = 0; i < 4; i++) step(tag, code4[15 - 4*i -: 4], 1'b1, 1'b0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int x_cycles;
    bus.sym = 4'h0; bus.sym_valid = 1'b0; bus.clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // First edge after reset already accepts a symbol; then a correct code.
    enter4("first_code", 16'h1234);
    for (int i = 0; i < 3; i++) step("match_hold", 4'(i), 1'b1, 1'b0);
    step("match_clr", 4'h0, 1'b0, 1'b1);
    idle("idle", 5);

    // One wrong attempt: FAIL for a cycle, then fails=1.
    enter4("wrong1", 16'h1235);
    idle("fail_exit", 1);

    // Two more wrong attempts lead to lockout; strobes during it are ignored.
    enter4("wrong2", 16'h9234);
    idle("fail_exit2", 1);
    enter4("wrong3", 16'h1204);
    x_cycles = 0;
    for (int i = 0; i < LOCK_CYCLES + 4; i++) begin
      step("lockout", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (bus.x) x_cycles++;
    end
    check("lock_len", 32'(x_cycles), 32'(LOCK_CYCLES));
    enter4("after_lock", 16'h1234);
    step("clr2", 4'h0, 1'b0, 1'b1);

    // clr wins over a simultaneous strobe.
    step("pre_clr", 4'h1, 1'b1, 1'b0);
    step("pre_clr", 4'h2, 1'b1, 1'b0);
    step("clr_and_sym", 4'h3, 1'b1, 1'b1);
    enter4("post_clr", 16'h1234);
    step("clr3", 4'h0, 1'b0, 1'b1);

    // Asynchronous reset in the 5th lockout cycle.
    for (int a = 0; a < MAX_FAIL; a++) begin
      enter4("wrong_r", 16'h0000);
      if (a < MAX_FAIL - 1) idle("fail_r", 1);
    end
    idle("lock_r", 5);
    check("lock_r.in_lockout", 32'(bus.x), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.x", 32'(bus.x), 32'd0);
    check("async_rst.fails", 32'(bus.fails), 32'd0);
    check("async_rst.y", 32'(bus.y), 32'd0);
    check("async_rst.cnt", 32'(bus.cnt), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step("post_rst_sym", 4'h1, 1'b1, 1'b0);

    // Biased random stimulus: often type the right next symbol.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 2) != 0) ? code_at(entered.size()) : 4'($urandom_range(0, 15));
      step("rand", s, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
